// File: rtl/playbus_arbiter.sv
// ---------------------------------------------------------------------------
// playbus_arbiter
//
// Three-requester arbiter for the PlayBus control strobes. One requester is
// granted at a time; its latched func code is decoded onto the strobes for
// ACCESS_CYCLES cycles, then a one-cycle done pulse is returned to it.
//
// Build option:
//   PLAYBUS_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 > 1 > 2
//                          undefined -> round-robin from a last-winner pointer
//
// Handshake: a requester raises req[i] with req_func valid in the same cycle.
// The request is sampled only while the arbiter is idle; once gnt[i] rises,
// req and req_func are don't-care until done[i] pulses. The operation runs to
// completion even if req[i] drops. There is no back-pressure on done.
//
// o_dbg_state mirrors the FSM state (0 IDLE, 1 DRIVE, 2 DONE) for checkers.
// ---------------------------------------------------------------------------
module playbus_arbiter #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [2:0] req,
   input  logic [8:0] req_func,
   output logic [2:0] gnt,
   output logic [2:0] done,
   output logic       busy,
   output logic       ROMO,
   output logic       RAMO,
   output logic       RAMW,
   output logic       SWBEN,
   output logic       LEDLTCH,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Counter reload value; the counter counts DRIVE cycles remaining minus one.
   localparam logic [3:0] LP_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   // Strobe vector bit order: {ROMO, RAMO, RAMW, SWBEN, LEDLTCH}
   function automatic logic [4:0] decode_func(input logic [2:0] f);
      logic [4:0] s;
      s = 5'b00000;
      case (f)
         3'd1:    s = 5'b10000;   // ROMO
         3'd2:    s = 5'b01000;   // RAMO
         3'd3:    s = 5'b00110;   // RAMW + SWBEN
         3'd4:    s = 5'b00010;   // SWBEN
         3'd5:    s = 5'b01001;   // RAMO + LEDLTCH
         default: s = 5'b00000;   // 0, 6, 7: no strobe, sequence still runs
      endcase
      return s;
   endfunction

   // Round-robin pick: search starts at ptr+1 and wraps modulo 3.
   // Returns {found, index[1:0]}.
   function automatic logic [2:0] rr_pick(input logic [1:0] ptr,
                                          input logic [2:0] r);
      logic [2:0] res;
      int         idx;
      res = 3'b000;
      for (int k = 0; k < 3; k++) begin
         idx = (int'(ptr) + 1 + k) % 3;
         if (!res[2] && r[idx]) begin
            res = {1'b1, 2'(idx)};
         end
      end
      return res;
   endfunction

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [1:0] r_ptr;
   logic [1:0] r_winner;
   logic [2:0] r_func;
   logic [2:0] r_gnt;
   logic [2:0] r_done;
   logic       r_busy;
   logic [4:0] r_strobe;

   logic       w_found;
   logic [1:0] w_winner;
   logic [2:0] w_sel_func;
   logic [2:0] w_gnt_onehot;

   // Arbitration among current requests (only consumed in IDLE)
   always_comb begin
      w_found  = 1'b0;
      w_winner = 2'd0;
`ifdef PLAYBUS_FIXED_PRIO_EN
      if (req[0]) begin
         w_found  = 1'b1;
         w_winner = 2'd0;
      end else if (req[1]) begin
         w_found  = 1'b1;
         w_winner = 2'd1;
      end else if (req[2]) begin
         w_found  = 1'b1;
         w_winner = 2'd2;
      end
`else
      {w_found, w_winner} = rr_pick(r_ptr, req);
`endif
   end

   // Select the winner's func code and build its one-hot grant
   always_comb begin
      w_sel_func   = 3'd0;
      w_gnt_onehot = 3'b000;
      case (w_winner)
         2'd0: begin
            w_sel_func   = req_func[2:0];
            w_gnt_onehot = 3'b001;
         end
         2'd1: begin
            w_sel_func   = req_func[5:3];
            w_gnt_onehot = 3'b010;
         end
         2'd2: begin
            w_sel_func   = req_func[8:6];
            w_gnt_onehot = 3'b100;
         end
         default: begin
            w_sel_func   = 3'd0;
            w_gnt_onehot = 3'b000;
         end
      endcase
   end

   // Control FSM: IDLE -> DRIVE (ACCESS_CYCLES cycles) -> DONE -> IDLE
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_ptr    <= 2'd2;
         r_winner <= 2'd0;
         r_func   <= 3'd0;
         r_gnt    <= 3'b000;
         r_done   <= 3'b000;
         r_busy   <= 1'b0;
         r_strobe <= 5'b00000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done   <= 3'b000;
               r_strobe <= 5'b00000;
               if (w_found) begin
                  r_state  <= ST_DRIVE;
                  r_winner <= w_winner;
                  r_func   <= w_sel_func;
                  r_gnt    <= w_gnt_onehot;
                  r_cnt    <= LP_CNT_LOAD;
                  r_busy   <= 1'b1;
                  // Strobes go out in the first DRIVE cycle
                  r_strobe <= decode_func(w_sel_func);
               end
            end

            ST_DRIVE: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= ST_DONE;
                  r_strobe <= 5'b00000;
                  r_done   <= r_gnt;
               end else begin
                  r_cnt    <= r_cnt - 4'd1;
                  // Hold strobes from the latched code, not live req_func
                  r_strobe <= decode_func(r_func);
               end
            end

            ST_DONE: begin
               r_state  <= ST_IDLE;
               r_done   <= 3'b000;
               r_gnt    <= 3'b000;
               r_busy   <= 1'b0;
               r_strobe <= 5'b00000;
               r_ptr    <= r_winner;
            end

            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= 4'd0;
               r_gnt    <= 3'b000;
               r_done   <= 3'b000;
               r_busy   <= 1'b0;
               r_strobe <= 5'b00000;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign done        = r_done;
   assign busy        = r_busy;
   assign ROMO        = r_strobe[4];
   assign RAMO        = r_strobe[3];
   assign RAMW        = r_strobe[2];
   assign SWBEN       = r_strobe[1];
   assign LEDLTCH     = r_strobe[0];
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_playbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_playbus_arbiter: directed tests for playbus_arbiter, ACCESS_CYCLES = 2.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
// Strobe vectors are written {ROMO, RAMO, RAMW, SWBEN, LEDLTCH}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_playbus_arbiter;

  logic       clk;
  logic       n_reset;
  logic [2:0] req;
  logic [8:0] req_func;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       busy;
  logic       ROMO, RAMO, RAMW, SWBEN, LEDLTCH;
  logic [1:0] dbg_state;
  logic [4:0] strobes;

  int checks;
  int errors;

  assign strobes = {ROMO, RAMO, RAMW, SWBEN, LEDLTCH};

  playbus_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .req         (req),
    .req_func    (req_func),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .ROMO        (ROMO),
    .RAMO        (RAMO),
    .RAMW        (RAMW),
    .SWBEN       (SWBEN),
    .LEDLTCH     (LEDLTCH),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset  = 1'b0;
    req      = 3'b000;
    req_func = 9'd0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    n_reset  = 1'b0;
    req      = 3'b111;
    req_func = {3'd1, 3'd1, 3'd1};
    tick();
    tick();
    checks++;
    if ({gnt, done, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: gnt/done/busy=%b want 0000000", {gnt, done, busy});
    end
    checks++;
    if (strobes !== 5'b00000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000", strobes);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    req     = 3'b000;
    n_reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_single();
    do_reset();
    req      = 3'b001;
    req_func = {3'd0, 3'd0, 3'd1};
    tick();                                   // 1st cycle: grant + ROMO
    req = 3'b000;                             // drop req: op must still finish
    checks++;
    if ({gnt, busy, strobes} !== {3'b001, 1'b1, 5'b10000}) begin
      errors++;
      $display("FAIL single_c1: gnt/busy/str=%b want 001110000", {gnt, busy, strobes});
    end
    tick();                                   // 2nd cycle: ROMO still high
    checks++;
    if ({gnt, done, strobes} !== {3'b001, 3'b000, 5'b10000}) begin
      errors++;
      $display("FAIL single_c2: gnt/done/str=%b want 00100010000", {gnt, done, strobes});
    end
    tick();                                   // 3rd cycle: done pulse
    checks++;
    if ({gnt, done, busy, strobes} !== {3'b001, 3'b001, 1'b1, 5'b00000}) begin
      errors++;
      $display("FAIL single_done: gnt/done/busy/str=%b want 001001100000", {gnt, done, busy, strobes});
    end
    tick();                                   // 4th cycle: idle again
    checks++;
    if ({gnt, done, busy, strobes} !== 12'b0) begin
      errors++;
      $display("FAIL single_idle: gnt/done/busy/str=%b want 0", {gnt, done, busy, strobes});
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_contention();
    logic [2:0] exp_gnt [4];
    logic [4:0] exp_str [4];
`ifdef PLAYBUS_FIXED_PRIO_EN
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_str = '{5'b01000, 5'b01000, 5'b01000, 5'b01000};
`else
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_str = '{5'b01000, 5'b00110, 5'b01001, 5'b01000};
`endif
    do_reset();
    req      = 3'b111;
    req_func = {3'd5, 3'd3, 3'd2};
    for (int op = 0; op < 4; op++) begin
      tick();
      checks++;
      if ({gnt, strobes} !== {exp_gnt[op], exp_str[op]}) begin
        errors++;
        $display("FAIL cont_grant op%0d: gnt/str=%b want %b", op, {gnt, strobes}, {exp_gnt[op], exp_str[op]});
      end
      tick();
      checks++;
      if (strobes !== exp_str[op]) begin
        errors++;
        $display("FAIL cont_hold op%0d: str=%b want %b", op, strobes, exp_str[op]);
      end
      tick();
      checks++;
      if ({done, strobes} !== {exp_gnt[op], 5'b00000}) begin
        errors++;
        $display("FAIL cont_done op%0d: done/str=%b want %b", op, {done, strobes}, {exp_gnt[op], 5'b00000});
      end
      tick();                                 // IDLE, back-to-back re-arbitration
      checks++;
      if ({gnt, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL cont_idle op%0d: gnt/busy=%b want 0000", op, {gnt, busy});
      end
    end
    req = 3'b000;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_priority();
    logic [2:0] exp_gnt [3];
`ifdef PLAYBUS_FIXED_PRIO_EN
    exp_gnt = '{3'b010, 3'b010, 3'b010};
`else
    exp_gnt = '{3'b010, 3'b100, 3'b010};
`endif
    do_reset();
    req      = 3'b110;
    req_func = {3'd1, 3'd4, 3'd0};
    for (int op = 0; op < 3; op++) begin
      tick();
      checks++;
      if (gnt !== exp_gnt[op]) begin
        errors++;
        $display("FAIL prio_grant op%0d: gnt=%b want %b", op, gnt, exp_gnt[op]);
      end
      checks++;
      if (strobes !== ((exp_gnt[op] == 3'b010) ? 5'b00010 : 5'b10000)) begin
        errors++;
        $display("FAIL prio_strobe op%0d: str=%b", op, strobes);
      end
      tick();
      tick();
      tick();
    end
    req = 3'b000;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_abort();
    do_reset();
    req      = 3'b010;
    req_func = {3'd0, 3'd3, 3'd0};
    tick();                                   // 1st DRIVE cycle
    req = 3'b000;
    tick();                                   // 2nd DRIVE cycle
    checks++;
    if ({RAMW, SWBEN, gnt} !== {1'b1, 1'b1, 3'b010}) begin
      errors++;
      $display("FAIL abort_pre: RAMW/SWBEN/gnt=%b want 11010", {RAMW, SWBEN, gnt});
    end
    n_reset = 1'b0;
    tick();
    checks++;
    if ({gnt, done, busy, strobes, dbg_state} !== 14'b0) begin
      errors++;
      $display("FAIL abort_rst: gnt/done/busy/str/st=%b want 0", {gnt, done, busy, strobes, dbg_state});
    end
    n_reset = 1'b1;
    tick();
    checks++;
    if ({done, dbg_state} !== 5'b0) begin
      errors++;
      $display("FAIL abort_after: done/st=%b want 00000", {done, dbg_state});
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_illegal();
    do_reset();
    req      = 3'b100;
    req_func = {3'd7, 3'd0, 3'd0};
    tick();
    req      = 3'b000;
    req_func = {3'd1, 3'd1, 3'd1};           // must be ignored after grant
    checks++;
    if ({gnt, busy, strobes} !== {3'b100, 1'b1, 5'b00000}) begin
      errors++;
      $display("FAIL illegal_c1: gnt/busy/str=%b want 100100000", {gnt, busy, strobes});
    end
    tick();
    checks++;
    if ({strobes, dbg_state} !== {5'b00000, 2'd1}) begin
      errors++;
      $display("FAIL illegal_c2: str/st=%b want 0000001", {strobes, dbg_state});
    end
    tick();
    checks++;
    if ({done, strobes} !== {3'b100, 5'b00000}) begin
      errors++;
      $display("FAIL illegal_done: done/str=%b want 10000000", {done, strobes});
    end
    tick();
    checks++;
    if ({done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_end: done/busy=%b want 0000", {done, busy});
    end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    checks   = 0;
    errors   = 0;
    n_reset  = 1'b0;
    req      = 3'b000;
    req_func = 9'd0;
    test_reset();
    test_single();
    test_contention();
    test_priority();
    test_abort();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
